adc_sampler_mc: RTL and testbench



---
 rtl/adc_sampler_pkg.sv | 16 +
 rtl/sample_rate_divider.sv | 27 ++
 rtl/adc_sampler_mc.sv | 142 ++++++++++++++
 tb/tb_adc_sampler_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the multi-channel ADC sampler family.
package adc_sampler_pkg;

  localparam int AVG_LOG2_MAX = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_state_t;

  // Channel index width; a single-channel build still gets a 1-bit index.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sample_rate_divider.sv
// Programmable tick generator: one tick every rate_div+1 clk cycles while enabled.
module sample_rate_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // >= rather than == so lowering rate_div below the running count ticks at once.
  assign tick = enable && (div_cnt >= rate_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/adc_sampler_mc.sv
// Multi-channel ADC sampler: self-timed capture, optional block averaging,
// and a per-channel valid/ready word stream with sticky overrun.
module adc_sampler_mc
  import adc_sampler_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 0,
  parameter int DIV_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [DIV_W-1:0]          rate_div,
  input  logic [NUM_CH*ADC_W-1:0]   adc_data,
  output logic                      sample_pulse,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADC_W-1:0]          out_data,
  output logic [ch_w(NUM_CH)-1:0]   out_ch,
  output logic                      out_last,
  output logic                      overrun,
  input  logic                      clear_overrun
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]  LAST_IDX = CH_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 8 || AVG_LOG2 < 0 || AVG_LOG2 > AVG_LOG2_MAX) begin : g_param_check
    $error("adc_sampler_mc: unsupported NUM_CH or AVG_LOG2");
  end

  logic             tick;
  logic             frame_done;
  logic [ACC_W-1:0] acc   [NUM_CH];
  logic [ACC_W-1:0] sum   [NUM_CH];
  logic [CNT_W-1:0] acc_cnt;
  logic [ADC_W-1:0] frame [NUM_CH];
  fsm_state_t       state, state_nxt;
  logic [CH_W-1:0]  idx, idx_nxt;
  logic             hs, load, drop;

  sample_rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .rate_div (rate_div),
    .tick     (tick)
  );

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum[k] = acc[k] + ACC_W'(adc_data[k*ADC_W +: ADC_W]);
    end
  end

  assign frame_done = tick && (acc_cnt == CNT_LAST);

  // Capture stage: accumulate each tick, restart on frame completion or stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (!enable || frame_done) begin
      acc_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (tick) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
      for (int k = 0; k < NUM_CH; k++) acc[k] <= sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sample_pulse <= 1'b0;
    else        sample_pulse <= tick;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    drop      = 1'b0;
    out_valid = (state == SEND);
    out_last  = out_valid && (idx == LAST_IDX);
    out_ch    = idx;
    out_data  = out_valid ? frame[idx] : '0;
    hs        = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (frame_done) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      SEND: begin
        if (hs && out_last) begin
          // A frame finishing exactly as the last word leaves is not an overrun.
          idx_nxt = '0;
          if (frame_done) load = 1'b1;
          else            state_nxt = IDLE;
        end else begin
          if (hs) idx_nxt = idx + CH_W'(1);
          drop = frame_done;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output stage: frame buffer, stream FSM and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) frame[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_CH; k++) frame[k] <= ADC_W'(sum[k] >> AVG_LOG2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_adc_sampler_mc.sv
// Directed bench for adc_sampler_mc: one plain instance and one 4x-averaging instance.
module tb_adc_sampler_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en0, rdy0, clr0, sp0, v0, last0, ovr0;
  logic [15:0] rd0;
  logic [23:0] adc0;
  logic [11:0] d0;
  logic [0:0]  ch0;

  logic        en2, rdy2, clr2, sp2, v2, last2, ovr2;
  logic [15:0] rd2;
  logic [23:0] adc2;
  logic [11:0] d2;
  logic [0:0]  ch2;

  int checks = 0;
  int failures = 0;

  logic [13:0] q0[$];
  logic [13:0] q2[$];
  bit sb0, sb2, mon0, mon2, ptick0, ptick2;
  int m0, m2, mn2;
  int macc[2];

  adc_sampler_mc #(.NUM_CH(2), .ADC_W(12), .AVG_LOG2(0), .DIV_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .rate_div(rd0), .adc_data(adc0),
    .sample_pulse(sp0), .out_valid(v0), .out_ready(rdy0), .out_data(d0),
    .out_ch(ch0), .out_last(last0), .overrun(ovr0), .clear_overrun(clr0)
  );

  adc_sampler_mc #(.NUM_CH(2), .ADC_W(12), .AVG_LOG2(2), .DIV_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .rate_div(rd2), .adc_data(adc2),
    .sample_pulse(sp2), .out_valid(v2), .out_ready(rdy2), .out_data(d2),
    .out_ch(ch2), .out_last(last2), .overrun(ovr2), .clear_overrun(clr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q0.delete();
    q2.delete();
    m0 = 0; m2 = 0; mn2 = 0;
    macc = '{0, 0};
    ptick0 = 1'b0; ptick2 = 1'b0;
  endtask

  // One clock: sample at the falling edge, update the reference model, return just after the rising edge.
  task automatic cycle();
    bit t0, t2;
    logic [13:0] w;
    @(negedge clk);
    chk("pulse0", sp0, ptick0);
    chk("pulse2", sp2, ptick2);
    if (mon0 && v0 && rdy0) begin
      chk("word0_expected", q0.size() > 0, 1);
      if (q0.size() > 0) begin
        w = q0.pop_front();
        chk("word0", {last0, ch0, d0}, w);
      end
    end
    if (mon2 && v2 && rdy2) begin
      chk("word2_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        w = q2.pop_front();
        chk("word2", {last2, ch2, d2}, w);
      end
    end
    t0 = rst_n && en0 && (m0 >= int'(rd0));
    if (t0 && sb0) begin
      q0.push_back({1'b0, 1'b0, adc0[11:0]});
      q0.push_back({1'b1, 1'b1, adc0[23:12]});
    end
    m0 = (!rst_n || !en0 || t0) ? 0 : m0 + 1;
    ptick0 = t0;
    t2 = rst_n && en2 && (m2 >= int'(rd2));
    if (!rst_n || !en2) begin
      macc = '{0, 0};
      mn2 = 0;
    end else if (t2) begin
      if (mn2 == 3) begin
        if (sb2) begin
          q2.push_back({1'b0, 1'b0, 12'((macc[0] + int'(adc2[11:0])) >> 2)});
          q2.push_back({1'b1, 1'b1, 12'((macc[1] + int'(adc2[23:12])) >> 2)});
        end
        macc = '{0, 0};
        mn2 = 0;
      end else begin
        macc[0] += int'(adc2[11:0]);
        macc[1] += int'(adc2[23:12]);
        mn2++;
      end
    end
    m2 = (!rst_n || !en2 || t2) ? 0 : m2 + 1;
    ptick2 = t2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en0 = 0; rdy0 = 0; clr0 = 0; rd0 = '0; adc0 = '0;
    en2 = 0; rdy2 = 0; clr2 = 0; rd2 = '0; adc2 = '0;
    sb0 = 0; sb2 = 0; mon0 = 0; mon2 = 0;
    reset_model();
    repeat (3) cycle();
    chk("reset_u0", {sp0, v0, last0, ovr0, ch0, d0}, 0);
    chk("reset_u2", {sp2, v2, last2, ovr2, ch2, d2}, 0);
    rst_n = 1'b1;
    cycle();
    sb0 = 1; mon0 = 1; sb2 = 1; mon2 = 1;

    // Plain two-channel stream, period 4.
    rd0 = 16'd3; adc0 = {12'hABC, 12'h123}; rdy0 = 1; en0 = 1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (ptick0) begin
        chk("latency_valid", v0, 1);
        chk("latency_word", {last0, ch0, d0}, {1'b0, 1'b0, 12'h123});
      end
    end
    en0 = 0;
    repeat (3) cycle();
    chk("drain_plain", q0.size(), 0);

    // Period 2: last-word handshake meets the next completion, no gaps.
    rd0 = 16'd1; en0 = 1;
    for (int i = 0; i < 16; i++) begin
      adc0 = {12'(i * 7 + 5), 12'(i * 3 + 1)};
      cycle();
      if (i >= 1) chk("back_to_back_valid", v0, 1);
    end
    en0 = 0;
    repeat (3) cycle();
    chk("b2b_no_overrun", ovr0, 0);
    chk("drain_b2b", q0.size(), 0);

    // Stalled sink with a tick every cycle: hold, overrun, set-wins, clear.
    sb0 = 0; rd0 = 16'd0; rdy0 = 0; adc0 = {12'hABC, 12'h123}; en0 = 1;
    cycle();
    chk("stall_first_valid", v0, 1);
    chk("stall_no_overrun_yet", ovr0, 0);
    adc0 = {12'h456, 12'h789};
    cycle();
    chk("overrun_second_tick", ovr0, 1);
    repeat (8) cycle();
    chk("stall_hold", {v0, last0, ch0, d0}, {1'b1, 1'b0, 1'b0, 12'h123});
    clr0 = 1;
    cycle();
    chk("overrun_set_wins", ovr0, 1);
    en0 = 0;
    cycle();
    chk("overrun_cleared", ovr0, 0);
    clr0 = 0;
    q0.push_back({1'b0, 1'b0, 12'h123});
    q0.push_back({1'b1, 1'b1, 12'hABC});
    sb0 = 1; rdy0 = 1;
    repeat (3) cycle();
    chk("drain_stalled", q0.size(), 0);
    chk("stalled_idle", v0, 0);

    // Four-sample average, with no word before the fourth tick.
    rd2 = 16'd0; rdy2 = 1; en2 = 1;
    adc2 = {12'h001, 12'hFFF}; cycle(); chk("avg_quiet1", v2, 0);
    adc2 = {12'h002, 12'hFFF}; cycle(); chk("avg_quiet2", v2, 0);
    adc2 = {12'h003, 12'hFFF}; cycle(); chk("avg_quiet3", v2, 0);
    adc2 = {12'h004, 12'hFFC}; cycle();
    chk("avg_result", {v2, last2, ch2, d2}, {1'b1, 1'b0, 1'b0, 12'hFFE});
    en2 = 0;
    repeat (3) cycle();
    chk("drain_avg", q2.size(), 0);

    // Enable dropped mid-accumulation discards the partial sum.
    en2 = 1; adc2 = {12'h010, 12'h800};
    repeat (2) cycle();
    en2 = 0;
    cycle();
    en2 = 1; adc2 = {12'h010, 12'h100};
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fresh_quiet", v2, 0);
    end
    cycle();
    chk("fresh_avg", {v2, last2, ch2, d2}, {1'b1, 1'b0, 1'b0, 12'h100});
    en2 = 0;
    repeat (3) cycle();
    chk("drain_fresh", q2.size(), 0);

    // Asynchronous reset while a word is pending.
    sb0 = 0; rd0 = 16'd3; rdy0 = 0; adc0 = {12'hABC, 12'h123}; en0 = 1;
    repeat (9) cycle();
    chk("pre_reset_valid", v0, 1);
    chk("pre_reset_overrun", ovr0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {sp0, v0, last0, ovr0, ch0, d0}, 0);
    reset_model();
    cycle();
    rst_n = 1'b1;
    adc0 = {12'h0DE, 12'h0C5}; sb0 = 1; rdy0 = 1;
    repeat (4) cycle();
    chk("post_reset_word", {v0, ch0, d0}, {1'b1, 1'b0, 12'h0C5});
    en0 = 0;
    repeat (3) cycle();
    chk("drain_post_reset", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
